regfile_wb_arbiter: RTL and testbench

Write-side owner of the general-purpose register file's single write port. Merges two result sources: the in-order pipeline writeback, which has strict priority and never stalls, and a long-latency unit (e.g. divider), which uses a valid/ready handshake. Long-latency results wait in a small FIFO until the port is free. Newer pipeline writes kill stale buffered results to the same register, and the block reports buffered pending writes so decode can stall on them.

---
 rtl/regfile_wb_arbiter_if.sv | 49 ++++
 rtl/regfile_wb_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of register-file write-side signals: pipeline writeback, long-latency
// handshake, write port, pending-write lookup and FIFO occupancy.
interface regfile_wb_arbiter_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_waddr;
    logic [DATA_W-1:0] pipe_wdata;

    logic              lat_valid;
    logic [ADDR_W-1:0] lat_waddr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_ready;

    logic              reg_we;
    logic [ADDR_W-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_wdata;

    logic [ADDR_W-1:0] pend_raddr1;
    logic [ADDR_W-1:0] pend_raddr2;
    logic              pend_hit1;
    logic              pend_hit2;

    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output lat_valid, lat_waddr, lat_wdata,
        input  lat_ready,
        input  reg_we, reg_waddr, reg_wdata,
        output pend_raddr1, pend_raddr2,
        input  pend_hit1, pend_hit2,
        input  fifo_count
    );

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  lat_valid, lat_waddr, lat_wdata,
        output lat_ready,
        output reg_we, reg_waddr, reg_wdata,
        input  pend_raddr1, pend_raddr2,
        output pend_hit1, pend_hit2,
        output fifo_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Owns the register file write port: pipeline writeback has strict priority,
// long-latency results queue in a small FIFO and drain when the port is free.
module regfile_wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  live_reg;

    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;

    logic pipe_eff;
    logic lat_ready_int;
    logic push;
    logic pop;
    logic push_live;

    logic [DEPTH-1:0] occupied;
    logic [DEPTH-1:0] kill_vec;
    logic [DEPTH-1:0] hit1_vec;
    logic [DEPTH-1:0] hit2_vec;

    assign pipe_eff      = bus.pipe_we && (bus.pipe_waddr != '0);
    // Ready looks only at the registered count, never at a same-cycle pop.
    assign lat_ready_int = !rst && (count_reg < CNT_W'(DEPTH));
    assign push          = bus.lat_valid && lat_ready_int && (bus.lat_waddr != '0);
    assign pop           = !rst && !pipe_eff && (count_reg != '0);
    // A same-cycle pipeline write to the same register is newer; enqueue it dead.
    assign push_live     = !(pipe_eff && (bus.pipe_waddr == bus.lat_waddr));

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] offset;
            assign offset       = PTR_W'(gi) - rd_ptr_reg;
            assign occupied[gi] = CNT_W'(offset) < count_reg;
            assign kill_vec[gi] = pipe_eff && (addr_mem[gi] == bus.pipe_waddr);
            assign hit1_vec[gi] = occupied[gi] && live_reg[gi] &&
                                  (addr_mem[gi] == bus.pend_raddr1);
            assign hit2_vec[gi] = occupied[gi] && live_reg[gi] &&
                                  (addr_mem[gi] == bus.pend_raddr2);
        end
    endgenerate

    always_comb begin
        bus.reg_we     = 1'b0;
        bus.reg_waddr  = '0;
        bus.reg_wdata  = '0;
        if (!rst) begin
            if (pipe_eff) begin
                bus.reg_we    = 1'b1;
                bus.reg_waddr = bus.pipe_waddr;
                bus.reg_wdata = bus.pipe_wdata;
            end else if (count_reg != '0) begin
                // A killed head still uses its slot, but writes nothing.
                bus.reg_we    = live_reg[rd_ptr_reg];
                bus.reg_waddr = addr_mem[rd_ptr_reg];
                bus.reg_wdata = data_mem[rd_ptr_reg];
            end
        end
    end

    assign bus.lat_ready  = lat_ready_int;
    assign bus.fifo_count = rst ? '0 : count_reg;
    assign bus.pend_hit1  = !rst && (bus.pend_raddr1 != '0) && (|hit1_vec);
    assign bus.pend_hit2  = !rst && (bus.pend_raddr2 != '0) && (|hit2_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            live_reg   <= '0;
        end else begin
            count_reg <= count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_ptr_reg == PTR_W'(i)))
                    live_reg[i] <= push_live;
                else if (kill_vec[i])
                    live_reg[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= bus.lat_waddr;
            data_mem[wr_ptr_reg] <= bus.lat_wdata;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, drain, priority, kill,
// full/wrap, address-zero and mid-drain reset scenarios.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) bus ();

    regfile_wb_arbiter #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipe_we    = 1'b0;
        bus.pipe_waddr = '0;
        bus.pipe_wdata = '0;
        bus.lat_valid  = 1'b0;
        bus.lat_waddr  = '0;
        bus.lat_wdata  = '0;
    endtask

    task automatic lat(input logic [4:0] a, input logic [31:0] d);
        bus.lat_valid = 1'b1;
        bus.lat_waddr = a;
        bus.lat_wdata = d;
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        bus.pipe_we    = 1'b1;
        bus.pipe_waddr = a;
        bus.pipe_wdata = d;
    endtask

    task automatic port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        $display("step %s: we=%0b addr=%0d data=%0h cnt=%0d", tag,
                 bus.reg_we, bus.reg_waddr, bus.reg_wdata, bus.fifo_count);
        chk({tag, "_we"}, 64'(bus.reg_we), 64'(we));
        chk({tag, "_addr"}, 64'(bus.reg_waddr), 64'(a));
        chk({tag, "_data"}, 64'(bus.reg_wdata), 64'(d));
    endtask

    initial begin
        idle();
        bus.pend_raddr1 = 5'd5;
        bus.pend_raddr2 = 5'd0;

        // Reset with both sources active
        rst = 1'b1;
        lat(5'd5, 32'h1234);
        pipe(5'd7, 32'h5678);
        #1;
        port("rst", 1'b0, 5'd0, 32'd0);
        chk("rst_ready", 64'(bus.lat_ready), 64'd0);
        chk("rst_cnt", 64'(bus.fifo_count), 64'd0);
        chk("rst_hit1", 64'(bus.pend_hit1), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("post_rst_cnt", 64'(bus.fifo_count), 64'd0);
        chk("post_rst_ready", 64'(bus.lat_ready), 64'd1);
        port("post_rst", 1'b0, 5'd0, 32'd0);

        // Single long-latency result
        lat(5'd5, 32'hDEADBEEF);
        tick();
        idle();
        #1;
        port("single", 1'b1, 5'd5, 32'hDEADBEEF);
        chk("single_hit1", 64'(bus.pend_hit1), 64'd1);
        chk("single_cnt", 64'(bus.fifo_count), 64'd1);
        tick();
        chk("single_hit1_after", 64'(bus.pend_hit1), 64'd0);
        chk("single_cnt_after", 64'(bus.fifo_count), 64'd0);
        port("single_after", 1'b0, 5'd0, 32'd0);

        // Priority: pipe holds the port for three cycles
        lat(5'd3, 32'h11);
        tick();
        idle();
        pipe(5'd7, 32'h22);
        for (int k = 0; k < 3; k++) begin
            #1;
            port("prio_pipe", 1'b1, 5'd7, 32'h22);
            chk("prio_cnt", 64'(bus.fifo_count), 64'd1);
            tick();
        end
        idle();
        #1;
        port("prio_drain", 1'b1, 5'd3, 32'h11);
        chk("prio_cnt4", 64'(bus.fifo_count), 64'd1);
        tick();
        chk("prio_empty", 64'(bus.fifo_count), 64'd0);

        // Kill: newer pipeline write to the same register
        bus.pend_raddr1 = 5'd9;
        lat(5'd9, 32'hAA);
        tick();
        idle();
        pipe(5'd9, 32'hBB);
        #1;
        port("kill_pipe", 1'b1, 5'd9, 32'hBB);
        chk("kill_hit_before", 64'(bus.pend_hit1), 64'd1);
        tick();
        idle();
        #1;
        chk("kill_pop_we", 64'(bus.reg_we), 64'd0);
        chk("kill_hit_after", 64'(bus.pend_hit1), 64'd0);
        chk("kill_cnt", 64'(bus.fifo_count), 64'd1);
        tick();
        chk("kill_empty", 64'(bus.fifo_count), 64'd0);

        // Full and wrap
        pipe(5'd20, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            lat(5'(i), 32'h100 + 32'(i));
            #1;
            chk("fill_ready", 64'(bus.lat_ready), 64'd1);
            tick();
        end
        lat(5'd10, 32'h10A);
        bus.pend_raddr2 = 5'd3;
        #1;
        chk("full_ready", 64'(bus.lat_ready), 64'd0);
        chk("full_cnt", 64'(bus.fifo_count), 64'd4);
        chk("full_hit2", 64'(bus.pend_hit2), 64'd1);
        port("full_pipe", 1'b1, 5'd20, 32'h0);
        tick();
        bus.pend_raddr2 = 5'd0;
        bus.pipe_we = 1'b0;
        #1;
        chk("hit2_r0", 64'(bus.pend_hit2), 64'd0);
        chk("pop1_ready", 64'(bus.lat_ready), 64'd0);
        chk("pop1_cnt", 64'(bus.fifo_count), 64'd4);
        port("pop1", 1'b1, 5'd1, 32'h101);
        tick();
        chk("pop2_ready", 64'(bus.lat_ready), 64'd1);
        chk("pop2_cnt", 64'(bus.fifo_count), 64'd3);
        port("pop2", 1'b1, 5'd2, 32'h102);
        tick();
        idle();
        #1;
        chk("pushpop_cnt", 64'(bus.fifo_count), 64'd3);
        port("pop3", 1'b1, 5'd3, 32'h103);
        tick();
        port("pop4", 1'b1, 5'd4, 32'h104);
        tick();
        port("pop_wrap", 1'b1, 5'd10, 32'h10A);
        chk("wrap_cnt", 64'(bus.fifo_count), 64'd1);
        tick();
        chk("wrap_empty", 64'(bus.fifo_count), 64'd0);

        // Address zero on both sources
        lat(5'd0, 32'h55);
        #1;
        chk("r0_ready", 64'(bus.lat_ready), 64'd1);
        tick();
        idle();
        #1;
        chk("r0_cnt", 64'(bus.fifo_count), 64'd0);
        port("r0_nowrite", 1'b0, 5'd0, 32'd0);
        lat(5'd6, 32'h66);
        tick();
        idle();
        pipe(5'd0, 32'h77);
        #1;
        port("pipe_r0_pop", 1'b1, 5'd6, 32'h66);
        tick();
        chk("pipe_r0_empty", 64'(bus.fifo_count), 64'd0);

        // Reset mid-drain discards buffered results
        idle();
        pipe(5'd21, 32'h1);
        lat(5'd11, 32'hB1);
        tick();
        lat(5'd12, 32'hB2);
        tick();
        idle();
        chk("pre_rst_cnt", 64'(bus.fifo_count), 64'd2);
        rst = 1'b1;
        #1;
        port("mid_rst", 1'b0, 5'd0, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_cnt", 64'(bus.fifo_count), 64'd0);
        port("mid_rst_after", 1'b0, 5'd0, 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
